cajero_param: RTL and testbench
===============================

Name: cajero_param

Overview:
Parametrised successor to the ATM controller (cajero). It verifies a PIN of configurable digit count against a reference PIN, tracks failed attempts up to a configurable limit, and processes any number of deposits and withdrawals per card session. It holds the account balance internally and exposes it on a port. It sits between the card/keypad front end and the cash dispenser.

Parameters:
PIN_DIGITS, 4, number of BCD digits in the PIN; PIN port width is 4*PIN_DIGITS.
MONTO_W, 32, width of the transaction amount.
BAL_W, 64, width of the balance register; must be >= MONTO_W.
MAX_INTENTOS, 3, failed PIN attempts that cause Bloqueo (>= 2).
INIT_BALANCE, 0, balance value loaded at reset.

Ports:
CLK  in  1  single clock, rising edge.
Reset  in  1  asynchronous, active-low reset.
Tarjeta_recibida  in  1  level: high while a card is inserted.
PIN  in  4*PIN_DIGITS  reference PIN; digit 0 is the most significant nibble.
Digito  in  4  keypad digit.
Digito_STB  in  1  one-cycle strobe qualifying Digito.
Tipo_trans  in  1  0 = deposit, 1 = withdrawal; sampled with Monto_STB.
Monto  in  MONTO_W  transaction amount.
Monto_STB  in  1  one-cycle strobe qualifying Monto and Tipo_trans.
Balance  out  BAL_W  current balance.
Balance_actualizado  out  1  one-cycle pulse when the balance changes.
Entregar_dinero  out  1  one-cycle pulse when a withdrawal is accepted.
Fondos_insuficientes  out  1  one-cycle pulse when a withdrawal is rejected.
PIN_incorrecto  out  1  one-cycle pulse on each PIN mismatch.
Advertencia  out  1  level: high while failed count == MAX_INTENTOS-1.
Bloqueo  out  1  level: lock state; cleared only by Reset.

Behaviour:
- Reset (asynchronous, low):
  - State goes to ESPERA_TARJETA.
  - Balance = INIT_BALANCE; digit count and fail count = 0.
  - All pulse outputs, Advertencia and Bloqueo = 0.
- All outputs are registered.
- States: ESPERA_TARJETA, LEER_PIN, VERIF_PIN, ESPERA_TRANS, PROCESA, BLOQUEO.
- ESPERA_TARJETA -> LEER_PIN when Tarjeta_recibida=1. The digit buffer is cleared on entry.
- LEER_PIN:
  - Each Digito_STB shifts Digito into the buffer and increments the digit count.
  - When the PIN_DIGITS-th digit is sampled, go to VERIF_PIN.
- VERIF_PIN (one cycle): compare the buffer to PIN.
  - Match: fail count = 0, go to ESPERA_TRANS.
  - Mismatch: fail count +1, PIN_incorrecto pulses. If the new count == MAX_INTENTOS, go to BLOQUEO; otherwise return to LEER_PIN with the buffer cleared.
  - Timing: PIN_incorrecto is visible in the cycle after the VERIF_PIN edge, i.e. 2 edges after the last digit is sampled.
- ESPERA_TRANS -> PROCESA on Monto_STB; Monto and Tipo_trans are latched.
- PROCESA (one cycle), then back to ESPERA_TRANS. Outputs and Balance update 2 edges after Monto_STB.
  - Deposit: Balance += zero-extended Monto, saturating at 2^BAL_W-1. Balance_actualizado pulses only if the value changed.
  - Withdrawal with Monto <= Balance: Balance -= Monto; Balance_actualizado and Entregar_dinero pulse together.
  - Withdrawal with Monto > Balance: Fondos_insuficientes pulses; Balance unchanged.
  - Monto = 0: no balance change and no Balance_actualizado; a withdrawal still pulses Entregar_dinero.
- BLOQUEO: absorbing. Bloqueo=1 and Advertencia=0. All inputs are ignored until Reset.
- Card removal (Tarjeta_recibida=0) in any non-BLOQUEO state:
  - Returns to ESPERA_TARJETA on the next edge and aborts any partial PIN or latched transaction.
  - It takes priority over a simultaneous Digito_STB or Monto_STB.
  - Fail count persists across sessions; it clears only on a correct PIN or Reset.
- Strobes arriving in a state that does not consume them are ignored.
- Reset asserted mid-operation overrides everything immediately.

Optional Feature:
CAJERO_LIMITE_RETIRO_EN.
- When defined:
  - Adds parameter LIMITE_RETIRO (default 500, width MONTO_W+8) and output Limite_excedido (1, one-cycle pulse).
  - A per-session accumulator of accepted withdrawals clears when entering LEER_PIN from ESPERA_TARJETA.
  - A withdrawal whose (accumulator + Monto) > LIMITE_RETIRO pulses Limite_excedido instead of Entregar_dinero. Balance is unchanged.
  - The limit check precedes the funds check.
- When undefined: the port, parameter and accumulator do not exist; behaviour is as above.

Test Plan:
1. PIN=16'h1234, INIT_BALANCE=1000; card in; digits 1,2,3,4; withdraw 300 -> Entregar_dinero and Balance_actualizado pulse 2 edges after Monto_STB; Balance=700.
2. Withdraw 701 at Balance=700 -> Fondos_insuficientes pulses; Balance stays 700. Then deposit 50 -> Balance=750.
3. Digits 1,2,3,5 twice -> two PIN_incorrecto pulses; Advertencia=1 after the second. Then 1,2,3,4 -> Advertencia=0, fail count=0.
4. Three wrong PINs -> Bloqueo=1. A further card, digits and Monto_STB cause no output change. Reset low -> Bloqueo=0, Balance=1000.
5. Remove card after 2 digits, reinsert, enter 1,2,3,4 -> accepted (buffer was cleared). Monto_STB in the same cycle as removal -> no balance change.
6. BAL_W=MONTO_W=8, balance 250, deposit 10 -> Balance=255 (saturated). With CAJERO_LIMITE_RETIRO_EN and LIMITE_RETIRO=500: withdraw 400, then 200 -> Limite_excedido pulses on the second.

Source files
------------

// File: rtl/cajero_param.sv
// cajero_param: parametrised ATM controller with PIN check, attempt lockout and balance handling.
// Optional per-session withdrawal limit enabled by defining CAJERO_LIMITE_RETIRO_EN.
module cajero_param #(
   parameter int unsigned      PIN_DIGITS   = 4,
   parameter int unsigned      MONTO_W      = 32,
   parameter int unsigned      BAL_W        = 64,
   parameter int unsigned      MAX_INTENTOS = 3,
   parameter logic [BAL_W-1:0] INIT_BALANCE = '0
`ifdef CAJERO_LIMITE_RETIRO_EN
   ,
   parameter logic [MONTO_W+7:0] LIMITE_RETIRO = (MONTO_W+8)'(500)
`endif
) (
   input  logic                    CLK,
   input  logic                    Reset,
   input  logic                    Tarjeta_recibida,
   input  logic [4*PIN_DIGITS-1:0] PIN,
   input  logic [3:0]              Digito,
   input  logic                    Digito_STB,
   input  logic                    Tipo_trans,
   input  logic [MONTO_W-1:0]      Monto,
   input  logic                    Monto_STB,
   output logic [BAL_W-1:0]        Balance,
   output logic                    Balance_actualizado,
   output logic                    Entregar_dinero,
   output logic                    Fondos_insuficientes,
   output logic                    PIN_incorrecto,
   output logic                    Advertencia,
   output logic                    Bloqueo
`ifdef CAJERO_LIMITE_RETIRO_EN
   ,
   output logic                    Limite_excedido
`endif
);

   localparam int unsigned PIN_W  = 4 * PIN_DIGITS;
   localparam int unsigned CNT_W  = $clog2(PIN_DIGITS + 1);
   localparam int unsigned FAIL_W = $clog2(MAX_INTENTOS + 1);

   typedef enum logic [2:0] {
      ESPERA_TARJETA,
      LEER_PIN,
      VERIF_PIN,
      ESPERA_TRANS,
      PROCESA,
      BLOQUEO
   } state_t;

   state_t              state;
   logic [PIN_W-1:0]    buf_q;
   logic [CNT_W-1:0]    dig_cnt;
   logic [FAIL_W-1:0]   fail_cnt;
   logic [MONTO_W-1:0]  monto_q;
   logic                tipo_q;

   logic [PIN_W-1:0]    buf_next;
   logic [FAIL_W-1:0]   fail_next;
   logic [BAL_W-1:0]    monto_ext;
   logic [BAL_W:0]      dep_sum;
   logic [BAL_W-1:0]    dep_val;
   logic                fondos_ok;

   // Datapath helpers: digit shift, saturating deposit, funds check
   always_comb begin
      buf_next  = (buf_q << 4) | PIN_W'(Digito);
      fail_next = fail_cnt + FAIL_W'(1);
      monto_ext = BAL_W'(monto_q);
      dep_sum   = {1'b0, Balance} + (BAL_W+1)'(monto_q);
      dep_val   = dep_sum[BAL_W] ? {BAL_W{1'b1}} : dep_sum[BAL_W-1:0];
      fondos_ok = (monto_ext <= Balance);
   end

`ifdef CAJERO_LIMITE_RETIRO_EN
   localparam int unsigned ACC_W = MONTO_W + 8;

   logic [ACC_W-1:0] acc_q;
   logic [ACC_W:0]   acc_sum;
   logic             limite_ok;

   // Accepted withdrawals never push the accumulator past the limit, so ACC_W bits suffice
   always_comb begin
      acc_sum   = (ACC_W+1)'(acc_q) + (ACC_W+1)'(monto_q);
      limite_ok = (acc_sum <= (ACC_W+1)'(LIMITE_RETIRO));
   end
`endif

   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         state                <= ESPERA_TARJETA;
         buf_q                <= '0;
         dig_cnt              <= '0;
         fail_cnt             <= '0;
         monto_q              <= '0;
         tipo_q               <= 1'b0;
         Balance              <= INIT_BALANCE;
         Balance_actualizado  <= 1'b0;
         Entregar_dinero      <= 1'b0;
         Fondos_insuficientes <= 1'b0;
         PIN_incorrecto       <= 1'b0;
         Advertencia          <= 1'b0;
         Bloqueo              <= 1'b0;
`ifdef CAJERO_LIMITE_RETIRO_EN
         acc_q                <= '0;
         Limite_excedido      <= 1'b0;
`endif
      end else begin
         Balance_actualizado  <= 1'b0;
         Entregar_dinero      <= 1'b0;
         Fondos_insuficientes <= 1'b0;
         PIN_incorrecto       <= 1'b0;
`ifdef CAJERO_LIMITE_RETIRO_EN
         Limite_excedido      <= 1'b0;
`endif
         // Card removal aborts the session from any state except the lock
         if (state != BLOQUEO && !Tarjeta_recibida) begin
            state <= ESPERA_TARJETA;
         end else begin
            case (state)
               ESPERA_TARJETA: begin
                  buf_q   <= '0;
                  dig_cnt <= '0;
`ifdef CAJERO_LIMITE_RETIRO_EN
                  acc_q   <= '0;
`endif
                  state   <= LEER_PIN;
               end

               LEER_PIN: begin
                  if (Digito_STB) begin
                     buf_q <= buf_next;
                     if (dig_cnt == CNT_W'(PIN_DIGITS - 1)) begin
                        dig_cnt <= '0;
                        state   <= VERIF_PIN;
                     end else begin
                        dig_cnt <= dig_cnt + CNT_W'(1);
                     end
                  end
               end

               VERIF_PIN: begin
                  if (buf_q == PIN) begin
                     fail_cnt    <= '0;
                     Advertencia <= 1'b0;
                     state       <= ESPERA_TRANS;
                  end else begin
                     fail_cnt       <= fail_next;
                     PIN_incorrecto <= 1'b1;
                     if (fail_next == FAIL_W'(MAX_INTENTOS)) begin
                        Bloqueo     <= 1'b1;
                        Advertencia <= 1'b0;
                        state       <= BLOQUEO;
                     end else begin
                        Advertencia <= (fail_next == FAIL_W'(MAX_INTENTOS - 1));
                        buf_q       <= '0;
                        dig_cnt     <= '0;
                        state       <= LEER_PIN;
                     end
                  end
               end

               ESPERA_TRANS: begin
                  if (Monto_STB) begin
                     monto_q <= Monto;
                     tipo_q  <= Tipo_trans;
                     state   <= PROCESA;
                  end
               end

               PROCESA: begin
                  state <= ESPERA_TRANS;
                  if (!tipo_q) begin
                     if (dep_val != Balance) begin
                        Balance             <= dep_val;
                        Balance_actualizado <= 1'b1;
                     end
`ifdef CAJERO_LIMITE_RETIRO_EN
                  end else if (!limite_ok) begin
                     Limite_excedido <= 1'b1;
`endif
                  end else if (fondos_ok) begin
                     Entregar_dinero <= 1'b1;
`ifdef CAJERO_LIMITE_RETIRO_EN
                     acc_q           <= acc_sum[ACC_W-1:0];
`endif
                     // A zero withdrawal dispenses nothing but leaves the balance untouched
                     if (monto_q != '0) begin
                        Balance             <= Balance - monto_ext;
                        Balance_actualizado <= 1'b1;
                     end
                  end else begin
                     Fondos_insuficientes <= 1'b1;
                  end
               end

               BLOQUEO: begin
                  state <= BLOQUEO;
               end

               default: begin
                  state <= ESPERA_TARJETA;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_cajero_param.sv
// tb_cajero_param: directed and randomized checks of cajero_param against a session-level model.
`timescale 1ns/1ps
module tb_cajero_param;

   localparam int unsigned MAXI    = 3;
   localparam logic [63:0] INIT    = 64'd1000;
   localparam logic [15:0] REF_PIN = 16'h1234;
   localparam longint unsigned LIMIT = 500;

   logic        clk;
   logic        rst_n;
   logic        tarjeta, digito_stb, tipo, monto_stb;
   logic [3:0]  digito;
   logic [31:0] monto;
   logic [63:0] balance;
   logic        bal_upd, entregar, fondos, pin_inc, advert, bloqueo;

   logic        s_tarjeta, s_dstb, s_tipo, s_mstb;
   logic [3:0]  s_digito;
   logic [7:0]  s_monto, s_balance;
   logic        s_upd, s_ent, s_fon, s_pinc, s_adv, s_blq;
`ifdef CAJERO_LIMITE_RETIRO_EN
   logic        limite, s_lim;
`endif

   int checks = 0;
   int errors = 0;

   // Reference model state: session-level view of the account
   logic [63:0]     m_bal;
   int unsigned     m_fail;
   bit              m_locked;
   bit              m_authed;
   longint unsigned m_acc;

   cajero_param #(
      .PIN_DIGITS(4), .MONTO_W(32), .BAL_W(64), .MAX_INTENTOS(MAXI), .INIT_BALANCE(INIT)
   ) dut (
      .CLK(clk), .Reset(rst_n), .Tarjeta_recibida(tarjeta), .PIN(REF_PIN),
      .Digito(digito), .Digito_STB(digito_stb), .Tipo_trans(tipo), .Monto(monto),
      .Monto_STB(monto_stb), .Balance(balance), .Balance_actualizado(bal_upd),
      .Entregar_dinero(entregar), .Fondos_insuficientes(fondos),
      .PIN_incorrecto(pin_inc), .Advertencia(advert), .Bloqueo(bloqueo)
`ifdef CAJERO_LIMITE_RETIRO_EN
      , .Limite_excedido(limite)
`endif
   );

   cajero_param #(
      .PIN_DIGITS(4), .MONTO_W(8), .BAL_W(8), .MAX_INTENTOS(MAXI), .INIT_BALANCE(8'd250)
   ) dut_sat (
      .CLK(clk), .Reset(rst_n), .Tarjeta_recibida(s_tarjeta), .PIN(REF_PIN),
      .Digito(s_digito), .Digito_STB(s_dstb), .Tipo_trans(s_tipo), .Monto(s_monto),
      .Monto_STB(s_mstb), .Balance(s_balance), .Balance_actualizado(s_upd),
      .Entregar_dinero(s_ent), .Fondos_insuficientes(s_fon),
      .PIN_incorrecto(s_pinc), .Advertencia(s_adv), .Bloqueo(s_blq)
`ifdef CAJERO_LIMITE_RETIRO_EN
      , .Limite_excedido(s_lim)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      m_bal    = INIT;
      m_fail   = 0;
      m_locked = 0;
      m_authed = 0;
      m_acc    = 0;
   endtask

   task automatic do_reset();
      tarjeta = 1'b0; digito_stb = 1'b0; monto_stb = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      chk("reset_balance", balance, INIT);
      chk("reset_bloqueo", 64'(bloqueo), 64'(0));
      chk("reset_advertencia", 64'(advert), 64'(0));
      @(negedge clk) rst_n = 1'b1;
      cyc();
   endtask

   task automatic insert_card();
      tarjeta = 1'b1;
      cyc();
      if (!m_locked) begin
         m_authed = 0;
         m_acc    = 0;
      end
   endtask

   task automatic remove_card();
      tarjeta = 1'b0;
      cyc();
      if (!m_locked) m_authed = 0;
   endtask

   task automatic enter_pin(input logic [15:0] p);
      bit exp_inc;
      for (int i = 0; i < 4; i++) begin
         digito     = p[15-4*i -: 4];
         digito_stb = 1'b1;
         cyc();
         digito_stb = 1'b0;
      end
      chk("pin_incorrecto_early", 64'(pin_inc), 64'(0));
      cyc();
      exp_inc = 0;
      if (!m_locked && !m_authed) begin
         if (p == REF_PIN) begin
            m_fail   = 0;
            m_authed = 1;
         end else begin
            m_fail++;
            exp_inc = 1;
            if (m_fail == MAXI) m_locked = 1;
         end
      end
      chk("pin_incorrecto", 64'(pin_inc), 64'(exp_inc));
      chk("advertencia", 64'(advert), 64'(!m_locked && m_fail == MAXI - 1));
      chk("bloqueo", 64'(bloqueo), 64'(m_locked));
   endtask

   task automatic transact(input logic t, input logic [31:0] m);
      logic [63:0] eb;
      bit e_upd, e_ent, e_fon, e_lim;
      tipo = t; monto = m; monto_stb = 1'b1;
      cyc();
      monto_stb = 1'b0;
      chk("early_pulse", 64'({bal_upd, entregar, fondos}), 64'(0));
      cyc();
      eb = m_bal; e_upd = 0; e_ent = 0; e_fon = 0; e_lim = 0;
      if (m_authed && !m_locked) begin
         if (!t) begin
            if (64'(m) > (64'hFFFF_FFFF_FFFF_FFFF - m_bal)) eb = 64'hFFFF_FFFF_FFFF_FFFF;
            else eb = m_bal + 64'(m);
            e_upd = (eb != m_bal);
         end else begin
`ifdef CAJERO_LIMITE_RETIRO_EN
            if (m_acc + longint'(m) > LIMIT) e_lim = 1;
            else
`endif
            if (64'(m) <= m_bal) begin
               e_ent = 1;
               e_upd = (m != 0);
               eb    = m_bal - 64'(m);
               m_acc = m_acc + longint'(m);
            end else begin
               e_fon = 1;
            end
         end
         m_bal = eb;
      end
      chk("balance", balance, m_bal);
      chk("balance_actualizado", 64'(bal_upd), 64'(e_upd));
      chk("entregar_dinero", 64'(entregar), 64'(e_ent));
      chk("fondos_insuficientes", 64'(fondos), 64'(e_fon));
`ifdef CAJERO_LIMITE_RETIRO_EN
      chk("limite_excedido", 64'(limite), 64'(e_lim));
`endif
   endtask

   task automatic remove_with_stb(input logic t, input logic [31:0] m);
      tarjeta = 1'b0; tipo = t; monto = m; monto_stb = 1'b1;
      cyc();
      monto_stb = 1'b0;
      cyc();
      if (!m_locked) m_authed = 0;
      chk("abort_balance", balance, m_bal);
      chk("abort_pulses", 64'({bal_upd, entregar, fondos}), 64'(0));
   endtask

   task automatic s_trans(input logic t, input logic [7:0] m);
      s_tipo = t; s_monto = m; s_mstb = 1'b1;
      cyc();
      s_mstb = 1'b0;
      cyc();
   endtask

   initial begin
      logic [15:0] wp;
      logic [31:0] rm;
      rst_n = 1'b0;
      tarjeta = 1'b0; digito = '0; digito_stb = 1'b0; tipo = 1'b0; monto = '0; monto_stb = 1'b0;
      s_tarjeta = 1'b0; s_digito = '0; s_dstb = 1'b0; s_tipo = 1'b0; s_monto = '0; s_mstb = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("init_balance", balance, INIT);
      chk("init_flags", 64'({bloqueo, advert, pin_inc, bal_upd, entregar, fondos}), 64'(0));
      chk("init_sat_balance", 64'(s_balance), 64'(250));
      @(negedge clk) rst_n = 1'b1;
      cyc();

      // Withdrawal, insufficient funds, deposit
      insert_card();
      enter_pin(16'h1234);
      transact(1'b1, 32'd300);
      chk("t1_balance_700", balance, 64'd700);
      transact(1'b1, 32'd701);
      transact(1'b0, 32'd50);
      chk("t2_balance_750", balance, 64'd750);
      transact(1'b1, 32'd0);
      transact(1'b0, 32'd0);
      remove_card();

      // Per-session withdrawal accumulation
      insert_card();
      enter_pin(16'h1234);
      transact(1'b1, 32'd400);
      transact(1'b1, 32'd200);
      remove_card();

      // Warning after two failures, cleared by a correct PIN
      insert_card();
      enter_pin(16'h1235);
      cyc();
      chk("pin_pulse_one_cycle", 64'(pin_inc), 64'(0));
      enter_pin(16'h1235);
      chk("t3_advertencia_set", 64'(advert), 64'(1));
      enter_pin(16'h1234);
      chk("t3_advertencia_clear", 64'(advert), 64'(0));
      remove_card();
      insert_card();
      enter_pin(16'h9999);
      enter_pin(16'h1234);
      remove_card();

      // Lockout and reset
      insert_card();
      enter_pin(16'h0000);
      enter_pin(16'h0001);
      enter_pin(16'h0002);
      chk("t4_bloqueo", 64'(bloqueo), 64'(1));
      remove_card();
      insert_card();
      enter_pin(16'h1234);
      transact(1'b0, 32'd100);
      chk("t4_still_locked", 64'(bloqueo), 64'(1));
      do_reset();
      chk("t4_unlocked", 64'(bloqueo), 64'(0));

      // Card removal mid-PIN, then removal racing a transaction strobe
      insert_card();
      for (int i = 1; i <= 2; i++) begin
         digito = 4'(i); digito_stb = 1'b1;
         cyc();
         digito_stb = 1'b0;
      end
      remove_card();
      insert_card();
      enter_pin(16'h1234);
      chk("t5_accepted_no_warning", 64'({pin_inc, advert}), 64'(0));
      transact(1'b0, 32'd20);
      remove_with_stb(1'b1, 32'd5);

      // Randomized sessions
      for (int s = 0; s < 40; s++) begin
         insert_card();
         if ($urandom_range(0, 3) == 0) begin
            wp = 16'($urandom);
            if (wp == REF_PIN) wp = 16'h4321;
            enter_pin(wp);
         end
         enter_pin(REF_PIN);
         for (int k = 0; k < int'($urandom_range(1, 6)); k++) begin
            case ($urandom_range(0, 3))
               0:       rm = 32'd0;
               1:       rm = 32'($urandom_range(1, 100));
               2:       rm = 32'($urandom_range(0, 2000));
               default: rm = m_bal[31:0] + 32'($urandom_range(0, 1));
            endcase
            transact(1'($urandom_range(0, 1)), rm);
         end
         if ($urandom_range(0, 5) == 0) remove_with_stb(1'b0, 32'd77);
         else remove_card();
         if (m_locked) do_reset();
      end

      // Saturating narrow balance
      s_tarjeta = 1'b1;
      cyc();
      for (int i = 0; i < 4; i++) begin
         s_digito = 4'(i + 1); s_dstb = 1'b1;
         cyc();
         s_dstb = 1'b0;
      end
      cyc();
      chk("sat_pin_flags", 64'({s_pinc, s_adv, s_blq}), 64'(0));
      s_trans(1'b0, 8'd10);
      chk("sat_balance_255", 64'(s_balance), 64'(255));
      chk("sat_upd", 64'(s_upd), 64'(1));
      s_trans(1'b0, 8'd5);
      chk("sat_hold_255", 64'(s_balance), 64'(255));
      chk("sat_no_upd", 64'(s_upd), 64'(0));
      s_trans(1'b1, 8'd255);
      chk("sat_withdraw_all", 64'({s_balance, s_ent, s_upd}), 64'({8'd0, 1'b1, 1'b1}));
      s_trans(1'b1, 8'd1);
      chk("sat_insufficient", 64'({s_balance, s_fon, s_ent}), 64'({8'd0, 1'b1, 1'b0}));
`ifdef CAJERO_LIMITE_RETIRO_EN
      chk("sat_no_limit", 64'(s_lim), 64'(0));
`endif
      s_tarjeta = 1'b0;
      cyc();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
